// File: rtl/psum_relu_quant.sv
// psum_relu_quant
// Downstream stage of the MAC column. Signed partial sums from the mac are
// accumulated into a bank of `depth` registers, one per output channel.
// A one-cycle drain pulse streams the bank out in index order. Each entry
// goes through ReLU, a logical right shift by `shift` and unsigned
// saturation to `bw` bits. The result is the next layer's activation.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   in_psum / in_addr / in_clear are valid
//   in_ready   block accepts input (only while accumulating)
//   in_psum    signed partial sum (psum_bw bits)
//   in_addr    bank entry index
//   in_clear   1: overwrite the entry, 0: saturating accumulate into it
//   drain      one-cycle pulse that starts streaming the bank out
//   out_valid  out_act / out_addr are valid
//   out_ready  consumer accepts the current output
//   out_act    quantized unsigned activation (bw bits)
//   out_addr   bank index that out_act came from
//   done       one-cycle pulse after the last entry has been handed off
module psum_relu_quant #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int depth   = 8,
   parameter int addr_bw = 3,
   parameter int shift   = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [psum_bw-1:0] in_psum,
   input  logic [addr_bw-1:0]        in_addr,
   input  logic                      in_clear,
   input  logic                      drain,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [bw-1:0]             out_act,
   output logic [addr_bw-1:0]        out_addr,
   output logic                      done
);

   typedef enum logic {ACC, DRAIN} state_t;

   state_t                    state, state_next;
   logic [addr_bw-1:0]        index, index_next;
   logic                      done_next;
   logic                      accept;
   logic                      release_entry;
   logic                      last_entry;

   logic signed [psum_bw-1:0] bank [depth];

   logic [psum_bw:0]          wide_sum;
   logic [psum_bw-1:0]        sat_sum;
   logic [psum_bw-1:0]        write_value;
   logic [psum_bw-1:0]        drain_entry;
   logic [psum_bw-1:0]        shifted;

   assign last_entry = (index == addr_bw'(depth - 1));

   // State, drain index and the done pulse register. Reset drops any drain
   // in progress, so a pending done is also discarded.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ACC;
         index <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         index <= index_next;
         done  <= done_next;
      end
   end

   // Next-state logic and handshake signals. While draining, in_valid and
   // drain are ignored; the index only moves on an accepted output.
   always_comb begin
      state_next    = state;
      index_next    = index;
      done_next     = 1'b0;
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      accept        = 1'b0;
      release_entry = 1'b0;
      case (state)
         ACC: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (drain) begin
               state_next = DRAIN;
               index_next = '0;
            end
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready) begin
               release_entry = 1'b1;
               if (last_entry) begin
                  index_next = '0;
                  state_next = ACC;
                  done_next  = 1'b1;
               end else begin
                  index_next = index + 1'b1;
               end
            end
         end
         default: state_next = ACC;
      endcase
   end

   // Saturating accumulate: the sum is formed one bit wider, and when the two
   // top bits disagree the true result left the signed range, so clamp toward
   // the sign of the wide result.
   always_comb begin
      wide_sum = {bank[in_addr][psum_bw-1], bank[in_addr]}
               + {in_psum[psum_bw-1], in_psum};
      if (wide_sum[psum_bw] != wide_sum[psum_bw-1]) begin
         sat_sum = wide_sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                     : {1'b0, {(psum_bw-1){1'b1}}};
      end else begin
         sat_sum = wide_sum[psum_bw-1:0];
      end
      write_value = in_clear ? in_psum : sat_sum;
   end

   // Bank storage. Writes happen only while accumulating; entries are zeroed
   // as they are handed off so the bank is empty after a full drain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < depth; i++) begin
            bank[i] <= '0;
         end
      end else begin
         if (accept) begin
            bank[in_addr] <= write_value;
         end
         if (release_entry) begin
            bank[index] <= '0;
         end
      end
   end

   // Output quantization: negative entries become 0, otherwise shift right
   // and clamp anything that does not fit in bw bits to all-ones. Outputs
   // are forced to 0 whenever nothing is being presented.
   always_comb begin
      drain_entry = bank[index];
      shifted     = drain_entry >> shift;
      out_act     = '0;
      out_addr    = '0;
      if (state == DRAIN) begin
         out_addr = index;
         if (drain_entry[psum_bw-1]) begin
            out_act = '0;
         end else if (|shifted[psum_bw-1:bw]) begin
            out_act = '1;
         end else begin
            out_act = shifted[bw-1:0];
         end
      end
   end

endmodule

// File: tb/tb_psum_relu_quant.sv
// tb_psum_relu_quant
// Directed testbench for psum_relu_quant. Inputs are driven and outputs are
// sampled on the falling clock edge. A table of clear-writes covers the
// quantization corners; hand-written sequences cover accumulation,
// saturation, back-pressure, same-cycle write/drain and mid-drain reset.
module tb_psum_relu_quant;

   logic               clk;
   logic               reset_n;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] in_psum;
   logic [2:0]         in_addr;
   logic               in_clear;
   logic               drain;
   logic               out_valid;
   logic               out_ready;
   logic [3:0]         out_act;
   logic [2:0]         out_addr;
   logic               done;

   int checks   = 0;
   int failures = 0;

   logic [3:0] exp_act [8];

   typedef struct {
      logic [2:0]         addr;
      logic               clear;
      logic signed [15:0] psum;
      logic [3:0]         act;
   } vec_t;

   vec_t vecs [8];

   psum_relu_quant dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_psum   (in_psum),
      .in_addr   (in_addr),
      .in_clear  (in_clear),
      .drain     (drain),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_act   (out_act),
      .out_addr  (out_addr),
      .done      (done)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard bound on run time in case the sequencing ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int required);
      checks++;
      if (actual != required) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   // One accepted write; called on a falling edge, returns on the next one
   task automatic applyStimulus(input logic [2:0] addr, input logic clear,
                                input logic signed [15:0] psum);
      in_valid = 1'b1;
      in_addr  = addr;
      in_clear = clear;
      in_psum  = psum;
      @(negedge clk);
      in_valid = 1'b0;
      in_clear = 1'b0;
      in_psum  = '0;
   endtask

   task automatic clearExpected();
      for (int i = 0; i < 8; i++) exp_act[i] = '0;
   endtask

   // Full drain checked against exp_act. Optionally holds out_ready low at
   // one index (with an attempted write that must be ignored) and optionally
   // issues a write in the same cycle as the drain pulse.
   task automatic drainAndCheck(input string tag, input int hold_idx, input int hold_cycles,
                                input bit with_write, input logic [2:0] w_addr,
                                input logic signed [15:0] w_psum);
      out_ready = 1'b1;
      drain     = 1'b1;
      if (with_write) begin
         in_valid = 1'b1;
         in_addr  = w_addr;
         in_clear = 1'b1;
         in_psum  = w_psum;
      end
      @(negedge clk);
      drain    = 1'b0;
      in_valid = 1'b0;
      in_clear = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("%s out_valid[%0d]", tag, i), int'(out_valid), 1);
         checkOutput($sformatf("%s out_addr[%0d]", tag, i), int'(out_addr), i);
         checkOutput($sformatf("%s out_act[%0d]", tag, i), int'(out_act), int'(exp_act[i]));
         checkOutput($sformatf("%s in_ready[%0d]", tag, i), int'(in_ready), 0);
         checkOutput($sformatf("%s done_early[%0d]", tag, i), int'(done), 0);
         if (i == hold_idx) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_addr   = 3'd5;
            in_clear  = 1'b1;
            in_psum   = 16'sd1000;
            for (int h = 0; h < hold_cycles; h++) begin
               @(negedge clk);
               checkOutput($sformatf("%s hold out_valid[%0d]", tag, h), int'(out_valid), 1);
               checkOutput($sformatf("%s hold out_addr[%0d]", tag, h), int'(out_addr), i);
               checkOutput($sformatf("%s hold out_act[%0d]", tag, h), int'(out_act), int'(exp_act[i]));
               checkOutput($sformatf("%s hold in_ready[%0d]", tag, h), int'(in_ready), 0);
            end
            in_valid  = 1'b0;
            in_clear  = 1'b0;
            out_ready = 1'b1;
         end
         @(negedge clk);
      end
      checkOutput({tag, " done"}, int'(done), 1);
      checkOutput({tag, " out_valid_after"}, int'(out_valid), 0);
      checkOutput({tag, " out_act_after"}, int'(out_act), 0);
      checkOutput({tag, " out_addr_after"}, int'(out_addr), 0);
      checkOutput({tag, " in_ready_after"}, int'(in_ready), 1);
      @(negedge clk);
      checkOutput({tag, " done_once"}, int'(done), 0);
   endtask

   initial begin
      // Quantization table: each entry is a clear-write to its own address
      vecs[0] = '{3'd0, 1'b1,  16'sd100,   4'd6};
      vecs[1] = '{3'd1, 1'b1, -16'sd2000,  4'd0};
      vecs[2] = '{3'd2, 1'b1,  16'sd16,    4'd1};
      vecs[3] = '{3'd3, 1'b1,  16'sd239,   4'd14};
      vecs[4] = '{3'd4, 1'b1,  16'sd240,   4'd15};
      vecs[5] = '{3'd5, 1'b1,  16'sd400,   4'd15};
      vecs[6] = '{3'd6, 1'b1,  16'sd15,    4'd0};
      vecs[7] = '{3'd7, 1'b1,  16'sd32767, 4'd15};

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_psum   = '0;
      in_addr   = '0;
      in_clear  = 1'b0;
      drain     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset in_ready", int'(in_ready), 1);
      checkOutput("reset out_valid", int'(out_valid), 0);
      checkOutput("reset out_act", int'(out_act), 0);
      checkOutput("reset out_addr", int'(out_addr), 0);
      checkOutput("reset done", int'(done), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single clear-write, full drain
      clearExpected();
      applyStimulus(3'd2, 1'b1, 16'sd100);
      exp_act[2] = 4'd6;
      drainAndCheck("t1", -1, 0, 1'b0, 3'd0, 16'sd0);

      // Accumulation: 300-50=250 -> 15, 300-100=200 -> 12
      clearExpected();
      applyStimulus(3'd0, 1'b1, 16'sd300);
      applyStimulus(3'd0, 1'b0, -16'sd50);
      applyStimulus(3'd6, 1'b1, 16'sd300);
      applyStimulus(3'd6, 1'b0, -16'sd100);
      exp_act[0] = 4'd15;
      exp_act[6] = 4'd12;
      drainAndCheck("t2", -1, 0, 1'b0, 3'd0, 16'sd0);

      clearExpected();
      applyStimulus(3'd0, 1'b1, 16'sd400);
      exp_act[0] = 4'd15;
      drainAndCheck("t2b", -1, 0, 1'b0, 3'd0, 16'sd0);

      // ReLU and saturating accumulation in both directions
      clearExpected();
      applyStimulus(3'd1, 1'b1, -16'sd2000);
      applyStimulus(3'd3, 1'b1, 16'sd32767);
      applyStimulus(3'd3, 1'b0, 16'sd100);
      applyStimulus(3'd4, 1'b1, -16'sd32768);
      applyStimulus(3'd4, 1'b0, -16'sd32768);
      applyStimulus(3'd4, 1'b0, 16'sd32767);
      exp_act[3] = 4'd15;
      drainAndCheck("t3", -1, 0, 1'b0, 3'd0, 16'sd0);

      // Table-driven quantization corners
      clearExpected();
      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].addr, vecs[v].clear, vecs[v].psum);
         exp_act[vecs[v].addr] = vecs[v].act;
      end
      drainAndCheck("tab", -1, 0, 1'b0, 3'd0, 16'sd0);

      // Back-pressure for 5 cycles at index 2; write attempt must be ignored
      clearExpected();
      applyStimulus(3'd2, 1'b1, 16'sd100);
      applyStimulus(3'd0, 1'b1, 16'sd240);
      exp_act[0] = 4'd15;
      exp_act[2] = 4'd6;
      drainAndCheck("t4", 2, 5, 1'b0, 3'd0, 16'sd0);

      // Write in the same cycle as the drain pulse, then re-drain empty bank
      clearExpected();
      exp_act[7] = 4'd4;
      drainAndCheck("t5", -1, 0, 1'b1, 3'd7, 16'sd64);
      clearExpected();
      drainAndCheck("t5z", -1, 0, 1'b0, 3'd0, 16'sd0);

      // Reset in the middle of a drain
      for (int a = 0; a < 8; a++) applyStimulus(3'(a), 1'b1, 16'sd100);
      drain = 1'b1;
      @(negedge clk);
      drain = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("t6 pre out_act[%0d]", i), int'(out_act), 6);
         @(negedge clk);
      end
      checkOutput("t6 pre out_addr", int'(out_addr), 3);
      reset_n = 1'b0;
      #1;
      checkOutput("t6 rst out_valid", int'(out_valid), 0);
      checkOutput("t6 rst out_act", int'(out_act), 0);
      checkOutput("t6 rst out_addr", int'(out_addr), 0);
      checkOutput("t6 rst done", int'(done), 0);
      checkOutput("t6 rst in_ready", int'(in_ready), 1);
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput($sformatf("t6 no done[%0d]", c), int'(done), 0);
         checkOutput($sformatf("t6 in_ready[%0d]", c), int'(in_ready), 1);
      end
      clearExpected();
      drainAndCheck("t6z", -1, 0, 1'b0, 3'd0, 16'sd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
